// File: rtl/soc_system_key_debounce.sv
// soc_system_key_debounce: four independent pushbutton debouncers.
// Each key has a 2-flop synchronizer and a STABLE/PENDING FSM with a counter.
// key_out is the debounced active-low level; key_press pulses for one cycle on a press.
// Optional feature macro: SOC_SYSTEM_KEY_DEBOUNCE_PRESS_PULSE_EN builds the press-pulse
// registers; without it key_press is tied to zero.
module soc_system_key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_raw,
    output logic [3:0] key_out,
    output logic [3:0] key_press
);

    localparam int unsigned NKEYS = 4;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    logic [NKEYS-1:0] sync1_q;
    logic [NKEYS-1:0] sync2_q;
    logic [NKEYS-1:0] key_out_q;
    logic [NKEYS-1:0] key_out_d;
    state_e           state_q [NKEYS];
    state_e           state_d [NKEYS];
    logic [CNT_W-1:0] cnt_q   [NKEYS];
    logic [CNT_W-1:0] cnt_d   [NKEYS];

    // Two-flop synchronizer for the asynchronous pushbutton pins; idle level is released (1).
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-key FSM state, counter and debounced level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_out_q <= 4'hF;
            for (int i = 0; i < NKEYS; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            key_out_q <= key_out_d;
            for (int i = 0; i < NKEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state logic: a change must persist DEBOUNCE_CYCLES edges at sync2 to be accepted.
    always_comb begin
        key_out_d = key_out_q;
        for (int i = 0; i < NKEYS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (sync2_q[i] != key_out_q[i]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            // Single-cycle debounce accepts immediately; counter stays at 0.
                            key_out_d[i] = sync2_q[i];
                            cnt_d[i]     = '0;
                        end else begin
                            state_d[i] = ST_PENDING;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (sync2_q[i] == key_out_q[i]) begin
                        // Bounce back to the current level: discard the partial count.
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        key_out_d[i] = sync2_q[i];
                        state_d[i]   = ST_STABLE;
                        cnt_d[i]     = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    assign key_out = key_out_q;

`ifdef SOC_SYSTEM_KEY_DEBOUNCE_PRESS_PULSE_EN
    logic [NKEYS-1:0] key_press_q;
    logic [NKEYS-1:0] key_press_d;

    // A press is a debounced 1 -> 0 transition of key_out.
    always_comb begin
        key_press_d = key_out_q & ~key_out_d;
    end

    // One-cycle press pulse register, aligned with the key_out update.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_press_q <= 4'h0;
        end else begin
            key_press_q <= key_press_d;
        end
    end

    assign key_press = key_press_q;
`else
    assign key_press = 4'h0;
`endif

endmodule

// File: doc/soc_system_key_debounce.md
SOC_SYSTEM_KEY_DEBOUNCE -- requirements
Module: soc_system_key_debounce

Interface
REQ-001: Parameter DEBOUNCE_CYCLES, default 1000000, is the stable-input cycle count required to accept a key change (20 ms at 50 MHz); legal range is 1 to 2^24.
REQ-002: Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-003: Port reset, input, 1 bit, is a synchronous active-high reset.
REQ-004: Port key_raw, input, 4 bits, carries the asynchronous active-low pushbutton pins (0 = pressed).
REQ-005: Port key_out, output, 4 bits, is the debounced active-low key level, connected directly to the key PIO in_port.
REQ-006: Port key_press, output, 4 bits, carries one-cycle pulses on a debounced press (1 -> 0 transition of key_out).

Function
REQ-007: Each key_raw bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other logic uses it.
REQ-008: Each key SHALL have an independent FSM with states STABLE and PENDING, plus a counter of width clog2(DEBOUNCE_CYCLES)+1.
REQ-009: STABLE -> PENDING when sync2 != key_out, with the counter set to 1; when DEBOUNCE_CYCLES = 1, key_out updates on that same edge and the FSM stays in STABLE.
REQ-010: In PENDING, if sync2 == key_out, the FSM SHALL return to STABLE, clear the counter and leave key_out unchanged (bounce rejected).
REQ-011: In PENDING, if sync2 != key_out and the counter equals DEBOUNCE_CYCLES-1, the block SHALL set key_out <= sync2, clear the counter and enter STABLE; otherwise it increments the counter.
REQ-012: Latency: if key_raw[i] changes and is first sampled at edge N, then held steady, key_out[i] SHALL update at edge N+1+DEBOUNCE_CYCLES, exactly.
REQ-013: Any glitch shorter than DEBOUNCE_CYCLES consecutive cycles at sync2 SHALL leave key_out unchanged.
REQ-014: key_press[i] SHALL be registered high for exactly one cycle, on the same edge that key_out[i] goes 1 -> 0; a release (0 -> 1) produces no pulse.
REQ-015: Keys SHALL be fully independent; simultaneous changes on several keys SHALL update and pulse in the same cycle.
REQ-016: The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-017: While reset = 1 at a clock edge, the block SHALL set sync1 and sync2 to 4'hF, key_out to 4'hF, key_press to 4'h0, all FSMs to STABLE and all counters to 0.
REQ-018: A reset asserted mid-PENDING SHALL discard the partial count; after reset, a held-low key again requires the full latency from REQ-012.
REQ-019: The first edge with reset = 0 SHALL be treated as edge N for synchronizer sampling.

Configuration
REQ-020: Macro SOC_SYSTEM_KEY_DEBOUNCE_PRESS_PULSE_EN, when defined, SHALL compile in the press-pulse logic of REQ-014.
REQ-021: With SOC_SYSTEM_KEY_DEBOUNCE_PRESS_PULSE_EN undefined, key_press SHALL be constant 4'h0 and no pulse registers are built; key_out behaviour is identical.

Verification (DEBOUNCE_CYCLES = 8, macro defined unless stated)
REQ-022: Reset held 3 cycles with key_raw = 4'h0 -> key_out = 4'hF and key_press = 4'h0 throughout reset and for the first 9 edges after release.
REQ-023: key_raw = 4'hE first sampled at edge N and held -> key_out = 4'hE from edge N+9; key_press = 4'h1 for exactly edge N+9 only.
REQ-024: key_raw[1] low for 5 cycles, then high -> key_out stays 4'hF and key_press stays 4'h0; then held low for 8 or more cycles -> key_out = 4'hD.
REQ-025: key_raw = 4'h3 applied in one cycle and held -> key_out = 4'h3 and key_press = 4'hC in the same single cycle; then key_raw = 4'hF -> key_out = 4'hF after 9 edges with no pulse.
REQ-026: reset pulsed when the key-0 counter equals 5, key_raw[0] held low -> key_out = 4'hF immediately; key_out = 4'hE exactly 9 edges after the first post-reset edge.
REQ-027: Macro undefined, scenario REQ-023 repeated -> key_out timing identical, key_press = 4'h0 on every cycle.
